// File: rtl/lfsr_prbs_checker_if.sv
// Serial PRBS checker bus: data/valid/clear from the line side, lock and
// error reporting back from the checker.
interface lfsr_prbs_checker_if #(
    parameter int CNT_W = 16
);
    logic             din;
    logic             din_valid;
    logic             clr_count;
    logic             lock;
    logic             err_pulse;
    logic [CNT_W-1:0] err_count;

    modport master (
        output din,
        output din_valid,
        output clr_count,
        input  lock,
        input  err_pulse,
        input  err_count
    );

    modport slave (
        input  din,
        input  din_valid,
        input  clr_count,
        output lock,
        output err_pulse,
        output err_count
    );
endinterface

// File: rtl/lfsr_prbs_checker.sv
// Receive-side checker for the XNOR-feedback LFSR stream: self-synchronising lock
// detection, windowed loss-of-lock and a saturating bit-error counter.
module lfsr_prbs_checker #(
    parameter int WIDTH     = 10,
    parameter int TAP       = 7,
    parameter int LOCK_CNT  = 16,
    parameter int WINDOW    = 64,
    parameter int ERR_LIMIT = 4,
    parameter int CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    lfsr_prbs_checker_if.slave bus
);
    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WERR_W = $clog2(ERR_LIMIT + 1);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [WERR_W-1:0] WERR_LAST = WERR_W'(ERR_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

    state_e             state_r, state_s;
    logic [WIDTH-1:0]   sr_r, sr_s;
    logic [FILL_W-1:0]  fill_cnt_r, fill_cnt_s;
    logic [GOOD_W-1:0]  good_cnt_r, good_cnt_s;
    logic [WIN_W-1:0]   win_cnt_r, win_cnt_s;
    logic [WERR_W-1:0]  win_err_r, win_err_s;
    logic               lock_r, lock_s;
    logic               err_pulse_r, err_pulse_s;
    logic [CNT_W-1:0]   err_count_r, err_count_s;
    logic               pred_s;
    logic               miss_s;

    // sr_r[k-1] holds sr[k]; the prediction is the XNOR of the two taps.
    assign pred_s = ~(sr_r[TAP-1] ^ sr_r[WIDTH-1]);
    assign miss_s = bus.din ^ pred_s;

    assign bus.lock      = lock_r;
    assign bus.err_pulse = err_pulse_r;
    assign bus.err_count = err_count_r;

    // Next-state and output decode for the FILL / VERIFY / LOCKED machine.
    always_comb begin
        state_s     = state_r;
        sr_s        = sr_r;
        fill_cnt_s  = fill_cnt_r;
        good_cnt_s  = good_cnt_r;
        win_cnt_s   = win_cnt_r;
        win_err_s   = win_err_r;
        lock_s      = lock_r;
        err_pulse_s = 1'b0;
        if (bus.clr_count) begin
            err_count_s = {CNT_W{1'b0}};
        end else begin
            err_count_s = err_count_r;
        end

        if (bus.din_valid) begin
            case (state_r)
                ST_FILL: begin
                    sr_s = {sr_r[WIDTH-2:0], bus.din};
                    if (fill_cnt_r == FILL_LAST) begin
                        state_s    = ST_VERIFY;
                        fill_cnt_s = {FILL_W{1'b0}};
                        good_cnt_s = {GOOD_W{1'b0}};
                    end else begin
                        fill_cnt_s = fill_cnt_r + FILL_W'(1);
                    end
                end
                ST_VERIFY: begin
                    sr_s = {sr_r[WIDTH-2:0], bus.din};
                    if (miss_s) begin
                        state_s    = ST_FILL;
                        fill_cnt_s = {FILL_W{1'b0}};
                        good_cnt_s = {GOOD_W{1'b0}};
                    end else if (good_cnt_r == GOOD_LAST) begin
                        good_cnt_s = {GOOD_W{1'b0}};
                        // All-ones is the XNOR lock-up state: never a valid lock.
                        if (&sr_s) begin
                            state_s    = ST_FILL;
                            fill_cnt_s = {FILL_W{1'b0}};
                        end else begin
                            state_s   = ST_LOCKED;
                            lock_s    = 1'b1;
                            win_cnt_s = {WIN_W{1'b0}};
                            win_err_s = {WERR_W{1'b0}};
                        end
                    end else begin
                        good_cnt_s = good_cnt_r + GOOD_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (miss_s) begin
                        err_pulse_s = 1'b1;
                        err_count_s = sat_inc(err_count_s);
                    end else begin
                        err_pulse_s = 1'b0;
                    end
                    if (miss_s && (win_err_r == WERR_LAST)) begin
                        state_s    = ST_FILL;
                        lock_s     = 1'b0;
                        fill_cnt_s = {FILL_W{1'b0}};
                        win_cnt_s  = {WIN_W{1'b0}};
                        win_err_s  = {WERR_W{1'b0}};
                    end else begin
                        // The reference free-runs on its own prediction, immune to line errors.
                        sr_s = {sr_r[WIDTH-2:0], pred_s};
                        if (win_cnt_r == WIN_LAST) begin
                            win_cnt_s = {WIN_W{1'b0}};
                            win_err_s = {WERR_W{1'b0}};
                        end else if (miss_s) begin
                            win_cnt_s = win_cnt_r + WIN_W'(1);
                            win_err_s = win_err_r + WERR_W'(1);
                        end else begin
                            win_cnt_s = win_cnt_r + WIN_W'(1);
                        end
                    end
                end
                default: begin
                    state_s    = ST_FILL;
                    lock_s     = 1'b0;
                    fill_cnt_s = {FILL_W{1'b0}};
                    good_cnt_s = {GOOD_W{1'b0}};
                    win_cnt_s  = {WIN_W{1'b0}};
                    win_err_s  = {WERR_W{1'b0}};
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, reference register, counters and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_FILL;
            sr_r        <= {WIDTH{1'b0}};
            fill_cnt_r  <= {FILL_W{1'b0}};
            good_cnt_r  <= {GOOD_W{1'b0}};
            win_cnt_r   <= {WIN_W{1'b0}};
            win_err_r   <= {WERR_W{1'b0}};
            lock_r      <= 1'b0;
            err_pulse_r <= 1'b0;
            err_count_r <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            sr_r        <= sr_s;
            fill_cnt_r  <= fill_cnt_s;
            good_cnt_r  <= good_cnt_s;
            win_cnt_r   <= win_cnt_s;
            win_err_r   <= win_err_s;
            lock_r      <= lock_s;
            err_pulse_r <= err_pulse_s;
            err_count_r <= err_count_s;
        end
    end
endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Bench for lfsr_prbs_checker: directed steps with random line data, checked
// against a bit-history reference model of the lock/error rules.
module tb_lfsr_prbs_checker;
    localparam int WIDTH     = 10;
    localparam int TAP       = 7;
    localparam int LOCK_CNT  = 16;
    localparam int WINDOW    = 64;
    localparam int ERR_LIMIT = 4;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    lfsr_prbs_checker_if #(.CNT_W(16)) bus ();
    lfsr_prbs_checker_if #(.CNT_W(4))  bus4 ();

    assign bus4.din       = bus.din;
    assign bus4.din_valid = bus.din_valid;
    assign bus4.clr_count = bus.clr_count;

    lfsr_prbs_checker #(.CNT_W(16)) u_dut (.clk(clk), .reset(reset), .bus(bus));
    lfsr_prbs_checker #(.CNT_W(4))  u_dut4 (.clk(clk), .reset(reset), .bus(bus4));

    // Generator history and reference model state
    bit g_q[$];
    bit m_h[$];
    int m_mode, m_fill, m_good, m_win, m_werr, m_cnt, m_cnt4;
    bit m_lock, m_pulse;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit gen_next();
        bit b;
        b = !(g_q[$-(TAP-1)] ^ g_q[$-(WIDTH-1)]);
        g_q.push_back(b);
        void'(g_q.pop_front());
        return b;
    endfunction

    task automatic model_reset();
        g_q.delete();
        m_h.delete();
        repeat (WIDTH) begin
            g_q.push_back(1'b0);
            m_h.push_back(1'b0);
        end
        m_mode = 0; m_fill = 0; m_good = 0; m_win = 0; m_werr = 0;
        m_cnt = 0; m_cnt4 = 0; m_lock = 1'b0; m_pulse = 1'b0;
    endtask

    task automatic push_h(input bit b);
        m_h.push_back(b);
        void'(m_h.pop_front());
    endtask

    // mode 0 = filling, 1 = verifying, 2 = locked
    task automatic model_step(input bit d, input bit v, input bit c);
        bit p;
        int ones;
        m_pulse = 1'b0;
        if (c) begin
            m_cnt = 0;
            m_cnt4 = 0;
        end
        if (v) begin
            p = !(m_h[$-(TAP-1)] ^ m_h[$-(WIDTH-1)]);
            if (m_mode == 0) begin
                push_h(d);
                m_fill++;
                if (m_fill == WIDTH) begin
                    m_mode = 1;
                    m_good = 0;
                end
            end else if (m_mode == 1) begin
                push_h(d);
                if (d != p) begin
                    m_mode = 0;
                    m_fill = 0;
                end else begin
                    m_good++;
                    if (m_good == LOCK_CNT) begin
                        ones = 0;
                        foreach (m_h[k]) ones += int'(m_h[k]);
                        if (ones == WIDTH) begin
                            m_mode = 0;
                            m_fill = 0;
                        end else begin
                            m_mode = 2; m_lock = 1'b1; m_win = 0; m_werr = 0;
                        end
                    end
                end
            end else begin
                if (d != p) begin
                    m_pulse = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt4 < 15) m_cnt4++;
                    m_werr++;
                end
                if (m_werr == ERR_LIMIT) begin
                    m_mode = 0; m_lock = 1'b0; m_fill = 0;
                end else begin
                    push_h(p);
                    m_win++;
                    if (m_win == WINDOW) begin
                        m_win = 0;
                        m_werr = 0;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit d, input bit v, input bit c);
        bus.din = d;
        bus.din_valid = v;
        bus.clr_count = c;
        @(posedge clk);
        #1;
        model_step(d, v, c);
        chk("lock", 32'(bus.lock), 32'(m_lock));
        chk("err_pulse", 32'(bus.err_pulse), 32'(m_pulse));
        chk("err_count", 32'(bus.err_count), 32'(m_cnt));
        chk("err_count4", 32'(bus4.err_count), 32'(m_cnt4));
    endtask

    task automatic clean(input int n);
        for (int i = 0; i < n; i++) step(gen_next(), 1'b1, 1'b0);
    endtask

    task automatic mid_reset();
        #3;
        reset = 1'b0;
        #1;
        chk("rst_lock", 32'(bus.lock), 32'd0);
        chk("rst_pulse", 32'(bus.err_pulse), 32'd0);
        chk("rst_count", 32'(bus.err_count), 32'd0);
        chk("rst_count4", 32'(bus4.err_count), 32'd0);
        model_reset();
        #2;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        bus.din = 1'b0;
        bus.din_valid = 1'b0;
        bus.clr_count = 1'b0;
        model_reset();
        #7;
        chk("init_lock", 32'(bus.lock), 32'd0);
        chk("init_pulse", 32'(bus.err_pulse), 32'd0);
        chk("init_count", 32'(bus.err_count), 32'd0);
        #5;
        reset = 1'b1;

        // Clean stream from seed 0: lock exactly on the 26th bit
        for (int i = 1; i <= 1000; i++) begin
            step(gen_next(), 1'b1, 1'b0);
            if (i == 25) chk("lock_bit25", 32'(bus.lock), 32'd0);
            if (i == 26) chk("lock_bit26", 32'(bus.lock), 32'd1);
        end
        chk("clean_count", 32'(bus.err_count), 32'd0);

        // Single flipped bit
        step(!gen_next(), 1'b1, 1'b0);
        chk("flip1_pulse", 32'(bus.err_pulse), 32'd1);
        chk("flip1_count", 32'(bus.err_count), 32'd1);
        chk("flip1_lock", 32'(bus.lock), 32'd1);
        step(gen_next(), 1'b1, 1'b0);
        chk("flip1_pulse_end", 32'(bus.err_pulse), 32'd0);
        clean(100);
        chk("flip1_after", 32'(bus.err_count), 32'd1);

        // Twelve flips spaced 22 bits: never 4 inside any 64-bit span
        for (int i = 0; i < 12; i++) begin
            step(!gen_next(), 1'b1, 1'b0);
            clean(21);
        end
        chk("spaced_lock", 32'(bus.lock), 32'd1);
        chk("spaced_count", 32'(bus.err_count), 32'd13);

        // Four flips inside one window lose lock; relock 26 bits later
        for (int k = 0; k < WINDOW && m_win != 0; k++) step(gen_next(), 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            step(!gen_next(), 1'b1, 1'b0);
            chk("burst_pulse", 32'(bus.err_pulse), 32'd1);
            chk("burst_lock", 32'(bus.lock), (i < 4) ? 32'd1 : 32'd0);
        end
        chk("burst_count", 32'(bus.err_count), 32'd17);
        chk("burst_sat4", 32'(bus4.err_count), 32'd15);
        clean(25);
        chk("relock_25", 32'(bus.lock), 32'd0);
        clean(1);
        chk("relock_26", 32'(bus.lock), 32'd1);
        clean(30);

        // Clear coincident with an error leaves a count of one
        step(!gen_next(), 1'b1, 1'b1);
        chk("clr_err_count", 32'(bus.err_count), 32'd1);
        chk("clr_err_count4", 32'(bus4.err_count), 32'd1);
        chk("clr_err_lock", 32'(bus.lock), 32'd1);
        clean(5);

        // Reset while locked
        mid_reset();

        // Constant ones: lock-up state, never locks
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b0);
        chk("ones_lock", 32'(bus.lock), 32'd0);

        // Random line data
        for (int i = 0; i < 500; i++) step(1'($urandom_range(1, 0)), 1'b1, 1'b0);

        // Sparse valid on a clean stream
        step(1'b0, 1'b0, 1'b0);
        mid_reset();
        for (int i = 1; i <= 40; i++) begin
            step(gen_next(), 1'b1, 1'b0);
            if (i == 25) chk("sparse_lock25", 32'(bus.lock), 32'd0);
            if (i == 26) chk("sparse_lock26", 32'(bus.lock), 32'd1);
            step(1'($urandom_range(1, 0)), 1'b0, 1'b0);
            step(1'($urandom_range(1, 0)), 1'b0, 1'b0);
        end
        chk("sparse_count", 32'(bus.err_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
